// File: rtl/sram_controller_pkg.sv
// ============================================================================
// Module      : sram_controller_pkg
// Description : Shared widths, state encoding and address helper for the
//               32-bit-over-16-bit SRAM data-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_controller_pkg;

    localparam int REGISTER_LEN   = 32;
    localparam int SRAM_ADDR_LEN  = 18;
    localparam int SRAM_DATA_LEN  = 16;
    localparam int SRAM_INDEX_LEN = SRAM_ADDR_LEN - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_t;

    // Each word occupies two consecutive halfword locations, low half first.
    function automatic logic [SRAM_ADDR_LEN-1:0] halfword_addr(
        input logic [SRAM_INDEX_LEN-1:0] index,
        input logic                      hi
    );
        return {index, hi};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_wait_counter.sv
// ============================================================================
// Module      : sram_wait_counter
// Description : Loadable down-counter; last is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_wait_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             last
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign last = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/sram_controller.sv
// ============================================================================
// Module      : sram_controller
// Description : MEM-stage data memory responder; each 32-bit word is executed
//               as two 16-bit async SRAM accesses. Optional SRAM_RANGE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR  = 1024,
    parameter int unsigned SRAM_WAIT  = 5,
    parameter int unsigned SRAM_WORDS = 65536
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [REGISTER_LEN-1:0]  address,
    input  logic [REGISTER_LEN-1:0]  write_data,
    output logic [REGISTER_LEN-1:0]  read_data,
    output logic                     ready,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
    input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
    output logic                     sram_dq_oe,
    output logic                     sram_we_n
);

    localparam int CNT_W = $clog2(SRAM_WAIT);
    localparam logic [CNT_W-1:0] C_WAIT_LOAD = CNT_W'(SRAM_WAIT - 1);

    sram_state_t r_state, w_next_state;

    logic                      r_is_write;
    logic [SRAM_INDEX_LEN-1:0] r_index;
    logic [REGISTER_LEN-1:0]   r_wdata;
    logic [SRAM_DATA_LEN-1:0]  r_lo_half;
    logic [REGISTER_LEN-1:0]   r_read_data;

    logic [REGISTER_LEN-1:0]   w_offset;
    logic                      w_req;
    logic                      w_in_range;
    logic                      w_counter_load;
    logic                      w_last;
    logic                      w_unused;

    assign w_offset = address - REGISTER_LEN'(BASE_ADDR);
    assign w_req    = rd_en | wr_en;

`ifdef SRAM_RANGE_CHECK_EN
    assign w_in_range = (address >= REGISTER_LEN'(BASE_ADDR)) &&
                        ({2'b00, w_offset[REGISTER_LEN-1:2]} < REGISTER_LEN'(SRAM_WORDS));
`else
    // No check: upper index bits are dropped, so addresses wrap over the SRAM.
    assign w_in_range = 1'b1;
`endif

    assign w_unused = ^{w_offset[REGISTER_LEN-1:SRAM_INDEX_LEN+2], w_offset[1:0],
                        REGISTER_LEN'(SRAM_WORDS)};

    sram_wait_counter #(
        .WIDTH      (CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (w_counter_load),
        .load_value (C_WAIT_LOAD),
        .last       (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_counter_load = 1'b0;
        ready          = 1'b0;
        sram_addr      = halfword_addr(r_index, 1'b0);
        sram_dq_out    = '0;
        sram_dq_oe     = 1'b0;
        sram_we_n      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                ready = !w_req;
                if (w_req) begin
                    if (w_in_range) begin
                        w_next_state   = ST_LO;
                        w_counter_load = 1'b1;
                    end else begin
                        w_next_state   = ST_DONE;
                    end
                end
            end
            ST_LO: begin
                if (r_is_write) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = r_wdata[SRAM_DATA_LEN-1:0];
                    // Strobe rises on the final cycle so data/address are stable at the edge.
                    sram_we_n   = w_last;
                end
                if (w_last) begin
                    w_next_state   = ST_HI;
                    w_counter_load = 1'b1;
                end
            end
            ST_HI: begin
                sram_addr = halfword_addr(r_index, 1'b1);
                if (r_is_write) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = r_wdata[REGISTER_LEN-1:SRAM_DATA_LEN];
                    sram_we_n   = w_last;
                end
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                ready        = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_write  <= 1'b0;
            r_index     <= '0;
            r_wdata     <= '0;
            r_lo_half   <= '0;
            r_read_data <= '0;
        end else begin
            if (r_state == ST_IDLE && w_req) begin
                r_is_write <= wr_en;
                r_index    <= w_offset[SRAM_INDEX_LEN+1:2];
                r_wdata    <= write_data;
                if (!w_in_range && !wr_en) begin
                    r_read_data <= '0;
                end
            end
            if (r_state == ST_LO && w_last && !r_is_write) begin
                r_lo_half <= sram_dq_in;
            end
            if (r_state == ST_HI && w_last && !r_is_write) begin
                r_read_data <= {sram_dq_in, r_lo_half};
            end
        end
    end

    assign read_data = r_read_data;

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// ============================================================================
// Module      : tb_sram_controller
// Description : Directed plus randomized bench for sram_controller against a
//               word-level memory model and a halfword SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_controller;

    localparam int unsigned BASE  = 1024;
    localparam int unsigned W     = 5;
    localparam int unsigned WORDS = 65536;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int total = 0;
    int bad   = 0;

    logic [15:0] sram_mem [0:255];
    logic [31:0] ref_mem  [0:127];
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    sram_controller #(
        .BASE_ADDR   (BASE),
        .SRAM_WAIT   (W),
        .SRAM_WORDS  (WORDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    // Asynchronous SRAM: reads are combinational, writes land while the strobe is low.
    assign sram_dq_in = sram_mem[sram_addr[7:0]];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr[7:0]] <= sram_dq_out;
    end

    function automatic logic [15:0] pat(input int h);
        return 16'(h * 4951) ^ 16'h5A5A;
    endfunction

    function automatic logic [63:0] bus_vec(input logic rdy, input logic oe, input logic wen,
                                            input logic [17:0] a, input logic [15:0] d);
        return {27'd0, rdy, oe, wen, a, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete word transaction, checked cycle by cycle against the phase timeline.
    task automatic run_op(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] data, input bit gap);
        logic [16:0] idx;
        logic [15:0] dq_e;
        logic [15:0] dq_o;
        logic        we_e;
        logic        hi;
        if (gap) begin
            rd_en = 1'b0;
            wr_en = 1'b0;
            #1;
            check("idle_ready", 64'(ready), 64'd1);
            step();
        end
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = data;
        #1;
        check("req_ready_low", 64'(ready), 64'd0);
        idx = 17'((addr - BASE) >> 2);
        step();
        for (int c = 1; c <= 2 * W; c++) begin
            rd_en      = 1'($urandom);
            wr_en      = 1'($urandom);
            address    = $urandom;
            write_data = $urandom;
            #1;
            hi   = (c > W);
            dq_e = wr ? (hi ? data[31:16] : data[15:0]) : 16'h0;
            dq_o = wr ? sram_dq_out : 16'h0;
            we_e = !(wr && c != W && c != 2 * W);
            check($sformatf("phase_c%0d_a%h", c, addr),
                  bus_vec(ready, sram_dq_oe, sram_we_n, sram_addr, dq_o),
                  bus_vec(1'b0, wr, we_e, {idx, hi}, dq_e));
            step();
        end
        rd_en      = 1'($urandom);
        wr_en      = 1'($urandom);
        address    = $urandom;
        write_data = $urandom;
        #1;
        check("done_ready", 64'({ready, sram_dq_oe, sram_we_n}), 64'(3'b101));
        if (wr) ref_mem[idx[6:0]] = data;
        else    exp_rdata = ref_mem[idx[6:0]];
        check($sformatf("read_data_a%h", addr), 64'(read_data), 64'(exp_rdata));
        step();
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd_addr;
        logic [31:0] rnd_data;
        bit          rnd_wr;
        for (int h = 0; h < 256; h++) sram_mem[h] = pat(h);
        for (int i = 0; i < 128; i++) ref_mem[i] = {pat(2 * i + 1), pat(2 * i)};
        exp_rdata  = 32'h0;
        rst        = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_bus", bus_vec(ready, sram_dq_oe, sram_we_n, sram_addr, sram_dq_out),
              bus_vec(1'b1, 1'b0, 1'b1, 18'h0, 16'h0));
        check("reset_read_data", 64'(read_data), 64'h0);

        run_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b1);
        run_op(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
        run_op(1'b1, 1'b0, 32'd1028, 32'hA5A5_0F0F, 1'b1);
        run_op(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        run_op(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b1);
        run_op(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);

        // Reset during cycle 3 of a write: low half is already in the SRAM.
        wr_en      = 1'b1;
        address    = BASE + 32'd12;
        write_data = 32'hCAFEF00D;
        step();
        wr_en = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("midop_reset_bus", bus_vec(ready, sram_dq_oe, sram_we_n, sram_addr, sram_dq_out),
              bus_vec(1'b1, 1'b0, 1'b1, 18'h0, 16'h0));
        check("midop_reset_read_data", 64'(read_data), 64'h0);
        ref_mem[3][15:0] = 16'hF00D;
        exp_rdata        = 32'h0;
        run_op(1'b0, 1'b1, BASE + 32'd12, 32'h0, 1'b1);

        for (int n = 0; n < 30; n++) begin
            rnd_wr   = 1'($urandom);
            rnd_addr = BASE + 32'(4 * $urandom_range(0, 127));
            rnd_data = $urandom;
            run_op(rnd_wr, rnd_wr ? 1'($urandom) : 1'b1, rnd_addr, rnd_data, 1'($urandom));
        end

`ifdef SRAM_RANGE_CHECK_EN
        run_op(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
        rd_en   = 1'b1;
        address = 32'd512;
        #1;
        check("oor_req_bus", 64'({ready, sram_dq_oe, sram_we_n}), 64'(3'b001));
        step();
        rd_en = 1'b0;
        #1;
        check("oor_done_bus", 64'({ready, sram_dq_oe, sram_we_n}), 64'(3'b101));
        check("oor_read_zero", 64'(read_data), 64'h0);
        exp_rdata = 32'h0;
        step();
        wr_en      = 1'b1;
        address    = BASE + 32'(4 * WORDS);
        write_data = 32'h11112222;
        step();
        wr_en = 1'b0;
        #1;
        check("oor_write_done", 64'({ready, sram_dq_oe, sram_we_n}), 64'(3'b101));
        check("oor_write_keeps_rdata", 64'(read_data), 64'(exp_rdata));
        step();
`else
        rnd_data = $urandom;
        run_op(1'b1, 1'b0, BASE + 32'(4 * (131072 + 5)), rnd_data, 1'b1);
        run_op(1'b0, 1'b1, BASE + 32'd20, 32'h0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
